// File: rtl/axi4_types.sv
// Shared AXI4 burst types, limits and helpers used by the read- and write-side
// address generators.
package axi4_types;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } burst_size_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } gen_state_t;

  localparam int BOUNDARY_4K   = 4096;
  localparam int MAX_BURST_LEN = 256;
  localparam int BEAT_IDX_W    = $clog2(MAX_BURST_LEN);

  function automatic logic [7:0] bytes_of(burst_size_t size);
    return 8'd1 << size;
  endfunction

  // (len+1) beats of 2^size bytes, minus one; 256 * 128 still fits in 16 bits.
  function automatic logic [15:0] wrap_mask(logic [7:0] len, burst_size_t size);
    logic [15:0] beats;
    beats = {8'd0, len} + 16'd1;
    return (beats << size) - 16'd1;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen_if.sv
// Command-in / beat-out bundle of the burst address generator.
// beat_err exists only when AXI4_BURST_ADDR_GEN_CHECK_EN is defined.
interface axi4_burst_addr_gen_if
  import axi4_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  burst_size_t           cmd_size;
  burst_type_t           cmd_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [7:0]            beat_idx;
  logic                  beat_last;
`ifdef AXI4_BURST_ADDR_GEN_CHECK_EN
  logic                  beat_err;
`endif

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last
`ifdef AXI4_BURST_ADDR_GEN_CHECK_EN
    , input beat_err
`endif
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last
`ifdef AXI4_BURST_ADDR_GEN_CHECK_EN
    , output beat_err
`endif
  );

endinterface

// File: rtl/axi4_beat_addr_next.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts; shared with
// the write-side generator.
module axi4_beat_addr_next
  import axi4_types::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  burst_size_t           size,
  input  burst_type_t           burst,
  input  logic [ADDR_WIDTH-1:0] wmask,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] nbytes;

  assign nbytes = ADDR_WIDTH'(bytes_of(size));

  // Reserved burst type falls through to INCR.
  always_comb begin
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wmask) | ((addr + nbytes) & wmask);
      default:     next_addr = (addr & ~(nbytes - 1'b1)) + nbytes;
    endcase
  end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 AR/AW command into a per-beat address stream.
// Optional legality flag on beat_err when AXI4_BURST_ADDR_GEN_CHECK_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | cmd_ready high, waiting for a command
//   ST_BURST | presenting beats until the last one is taken
module axi4_burst_addr_gen
  import axi4_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic                  aclk,
  input logic                  aresetn,
  axi4_burst_addr_gen_if.slave bus
);

  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
    $error("axi4_burst_addr_gen: DATA_WIDTH must be a power of 2 between 8 and 1024");
  end

  gen_state_t             state, next_state;
  logic                   cmd_ready_q;
  logic                   accept, beat_valid, beat_fire, at_last;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_next;
  logic [7:0]             len_q;
  logic [BEAT_IDX_W-1:0]  idx_q;
  burst_size_t            size_q;
  burst_type_t            burst_q;
  logic [15:0]            wmask_q;

  assign accept    = bus.cmd_valid & cmd_ready_q;
  assign beat_fire = beat_valid & bus.beat_ready;
  assign at_last   = (idx_q == len_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state       <= next_state;
      cmd_ready_q <= (next_state == ST_IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_BURST;
      ST_BURST: if (beat_fire && at_last) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_valid = (state == ST_BURST);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      size_q  <= SIZE_1B;
      burst_q <= BURST_FIXED;
      wmask_q <= '0;
    end else if (accept) begin
      id_q    <= bus.cmd_id;
      addr_q  <= bus.cmd_addr;
      len_q   <= bus.cmd_len;
      idx_q   <= '0;
      size_q  <= bus.cmd_size;
      burst_q <= bus.cmd_burst;
      wmask_q <= wrap_mask(bus.cmd_len, bus.cmd_size);
    end else if (beat_fire && !at_last) begin
      addr_q  <= addr_next;
      idx_q   <= idx_q + 1'b1;
    end
  end

  axi4_beat_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .wmask     (ADDR_WIDTH'(wmask_q)),
    .next_addr (addr_next)
  );

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.beat_valid = beat_valid;
  assign bus.beat_id    = id_q;
  assign bus.beat_addr  = addr_q;
  assign bus.beat_idx   = idx_q;
  assign bus.beat_last  = beat_valid & at_last;

`ifdef AXI4_BURST_ADDR_GEN_CHECK_EN
  localparam int BUS_BYTES = DATA_WIDTH / 8;

  logic        err_q, cmd_err;
  logic [7:0]  cmd_nbytes;
  logic [11:0] page_off;
  logic [16:0] incr_end;

  // INCR crosses 4 KB when the aligned in-page offset plus the burst span exceeds a page.
  always_comb begin
    cmd_nbytes = bytes_of(bus.cmd_size);
    page_off   = bus.cmd_addr[11:0] & ~(12'(cmd_nbytes) - 12'd1);
    incr_end   = {5'd0, page_off} + {1'b0, wrap_mask(bus.cmd_len, bus.cmd_size)} + 17'd1;
    cmd_err    = 1'b0;
    if (bus.cmd_burst == BURST_INCR && incr_end > 17'(BOUNDARY_4K)) cmd_err = 1'b1;
    if (bus.cmd_burst == BURST_WRAP && !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) cmd_err = 1'b1;
    if (bus.cmd_burst == BURST_WRAP && (bus.cmd_addr[7:0] & (cmd_nbytes - 8'd1)) != 8'd0) cmd_err = 1'b1;
    if (bus.cmd_burst == BURST_RSVD) cmd_err = 1'b1;
    if (int'(cmd_nbytes) > BUS_BYTES) cmd_err = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_q <= 1'b0;
    else if (accept) err_q <= cmd_err;
  end

  assign bus.beat_err = err_q;
`endif

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Scoreboard bench for axi4_burst_addr_gen: directed bursts, stalls, mid-burst reset
// and randomized commands against an arithmetic reference model.
`timescale 1ns/1ps
module tb_axi4_burst_addr_gen;
  import axi4_types::*;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int IW        = 4;
  localparam int BUS_BYTES = DW / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  axi4_burst_addr_gen_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi4_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    int            idx;
    bit            last;
    bit            err;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    ready_all = 1'b1;
  int    stall_idx = -1;
  int    stall_left = 0;

  function automatic void check(input string name, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endfunction

  function automatic bit model_err(input logic [AW-1:0] addr, input int len, input int size, input int burst);
    longint unsigned a  = addr;
    longint unsigned nb = 64'd1 << size;
    longint unsigned last_byte;
    bit e = 1'b0;
    if (burst == 3) e = 1'b1;
    if (nb > BUS_BYTES) e = 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
    if (burst == 2 && (a % nb) != 0) e = 1'b1;
    if (burst == 1) begin
      last_byte = (a / nb) * nb + longint'(len + 1) * nb - 1;
      if ((a >> 12) != (last_byte >> 12)) e = 1'b1;
    end
    return e;
  endfunction

  // Expected beats from the burst rules: FIXED repeats, INCR steps from the
  // aligned start, WRAP rotates inside its (len+1)*nbytes window.
  task automatic push_expected(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                               input int len, input int size, input int burst);
    longint unsigned a0    = addr;
    longint unsigned nb    = 64'd1 << size;
    longint unsigned total = longint'(len + 1) * nb;
    longint unsigned lower;
    logic [AW-1:0]   cur   = addr;
    logic [AW-1:0]   wm    = AW'(total - 1);
    bit              err   = model_err(addr, len, size, burst);
    beat_t           b;
    for (int n = 0; n <= len; n++) begin
      case (burst)
        0: cur = addr;
        2: begin
          if ((total & (total - 1)) == 0) begin
            lower = a0 - (a0 % total);
            cur   = AW'(lower + ((a0 - lower) + longint'(n) * nb) % total);
          end else if (n > 0) begin
            cur = (cur & ~wm) | ((cur + AW'(nb)) & wm);
          end
        end
        default: cur = (n == 0) ? addr : AW'((a0 / nb) * nb + longint'(n) * nb);
      endcase
      b.id   = id;
      b.addr = cur;
      b.idx  = n;
      b.last = (n == len);
      b.err  = err;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input int size, input int burst);
    int budget = 0;
    push_expected(id, addr, len, size, burst);
    @(posedge aclk); #1;
    bus.cmd_id    = id;
    bus.cmd_addr  = addr;
    bus.cmd_len   = 8'(len);
    bus.cmd_size  = burst_size_t'(3'(size));
    bus.cmd_burst = burst_type_t'(2'(burst));
    bus.cmd_valid = 1'b1;
    do begin
      @(negedge aclk);
      budget++;
    end while (!bus.cmd_ready && budget < 2000);
    check("cmd_accept", bus.cmd_ready, $sformatf("cmd_ready=%0b after %0d cycles, want 1", bus.cmd_ready, budget));
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 5000) begin
      @(posedge aclk);
      budget++;
    end
    repeat (3) @(posedge aclk);
    check(name, exp_q.size() == 0, $sformatf("%0d beats outstanding, want 0", exp_q.size()));
  endtask

  task automatic check_reset_outputs(input string name);
    bit ok;
    ok = !bus.cmd_ready && !bus.beat_valid && bus.beat_id == '0 && bus.beat_addr == '0 &&
         bus.beat_idx == '0 && !bus.beat_last;
`ifdef AXI4_BURST_ADDR_GEN_CHECK_EN
    ok = ok && !bus.beat_err;
`endif
    check(name, ok, $sformatf("cmd_ready=%0b valid=%0b id=%0h addr=%08h idx=%0d last=%0b, want all 0",
          bus.cmd_ready, bus.beat_valid, bus.beat_id, bus.beat_addr, bus.beat_idx, bus.beat_last));
  endtask

  task automatic release_reset();
    @(negedge aclk); #2;
    aresetn = 1'b1;
    check("cmd_ready_before_edge", !bus.cmd_ready, $sformatf("cmd_ready=%0b, want 0", bus.cmd_ready));
    @(posedge aclk); #1;
    check("cmd_ready_after_release", bus.cmd_ready, $sformatf("cmd_ready=%0b, want 1", bus.cmd_ready));
  endtask

  // Beat-ready driver: random, all-ones, or a 3-cycle stall when a chosen index appears.
  initial begin
    bus.beat_ready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (stall_left > 0) begin
        bus.beat_ready = 1'b0;
        stall_left--;
      end else if (stall_idx >= 0 && bus.beat_valid && int'(bus.beat_idx) == stall_idx) begin
        bus.beat_ready = 1'b0;
        stall_left = 2;
        stall_idx = -1;
      end else if (ready_all) begin
        bus.beat_ready = 1'b1;
      end else begin
        bus.beat_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
  logic [IW-1:0] snap_id;
  logic [AW-1:0] snap_addr;
  logic [7:0]    snap_idx;
  logic          snap_last;
  bit            hold_pend, after_last, after_acc, ok;
  beat_t         e;

  initial begin
    hold_pend  = 1'b0;
    after_last = 1'b0;
    after_acc  = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_q.delete();
        hold_pend  = 1'b0;
        after_last = 1'b0;
        after_acc  = 1'b0;
        continue;
      end
      if (after_acc)
        check("first_beat_latency", bus.beat_valid, $sformatf("beat_valid=%0b after accept, want 1", bus.beat_valid));
      if (after_last)
        check("turnaround_idle", !bus.beat_valid && bus.cmd_ready,
              $sformatf("beat_valid=%0b cmd_ready=%0b after last beat, want 0/1", bus.beat_valid, bus.cmd_ready));
      if (hold_pend)
        check("stall_hold", bus.beat_valid && bus.beat_addr == snap_addr && bus.beat_idx == snap_idx &&
              bus.beat_id == snap_id && bus.beat_last == snap_last,
              $sformatf("valid=%0b addr=%08h idx=%0d, want 1 addr=%08h idx=%0d",
                        bus.beat_valid, bus.beat_addr, bus.beat_idx, snap_addr, snap_idx));
      if (bus.beat_valid)
        check("cmd_ready_in_burst", !bus.cmd_ready, $sformatf("cmd_ready=%0b during burst, want 0", bus.cmd_ready));
      after_acc  = bus.cmd_valid && bus.cmd_ready;
      after_last = 1'b0;
      hold_pend  = 1'b0;
      if (bus.beat_valid && bus.beat_ready) begin
        check("beat_expected", exp_q.size() != 0,
              $sformatf("beat addr=%08h idx=%0d with empty scoreboard", bus.beat_addr, bus.beat_idx));
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          ok = bus.beat_id == e.id && bus.beat_addr == e.addr && int'(bus.beat_idx) == e.idx &&
               bus.beat_last == e.last;
`ifdef AXI4_BURST_ADDR_GEN_CHECK_EN
          ok = ok && (bus.beat_err == e.err);
`endif
          check("beat", ok, $sformatf("got id=%0h addr=%08h idx=%0d last=%0b, want id=%0h addr=%08h idx=%0d last=%0b err=%0b",
                bus.beat_id, bus.beat_addr, bus.beat_idx, bus.beat_last, e.id, e.addr, e.idx, e.last, e.err));
        end
        after_last = bus.beat_last;
      end else if (bus.beat_valid) begin
        snap_id   = bus.beat_id;
        snap_addr = bus.beat_addr;
        snap_idx  = bus.beat_idx;
        snap_last = bus.beat_last;
        hold_pend = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            wl[4];
    int            b, sz, ln, budget;
    logic [AW-1:0] a;
    bit            found;
    wl[0] = 1; wl[1] = 3; wl[2] = 7; wl[3] = 15;

    bus.cmd_valid = 1'b0;
    bus.cmd_id    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = SIZE_1B;
    bus.cmd_burst = BURST_FIXED;

    #2;
    check_reset_outputs("reset_outputs");
    repeat (2) @(posedge aclk);
    release_reset();

    ready_all = 1'b1;
    send_cmd(4'h1, 32'h0000_1002, 3, 2, 1);
    send_cmd(4'h2, 32'h0000_1038, 3, 2, 2);
    send_cmd(4'h3, 32'h0000_0020, 2, 2, 0);
    drain("drain_directed");

    stall_idx = 2;
    send_cmd(4'h4, 32'h0000_2000, 7, 2, 1);
    drain("drain_stall");

    send_cmd(4'h5, 32'h0000_0FF8, 3, 2, 1);
    send_cmd(4'h6, 32'h0000_0100, 2, 2, 2);
    send_cmd(4'h7, 32'h0000_0204, 3, 1, 3);
    send_cmd(4'h8, 32'hFFFF_FFF8, 3, 2, 1);
    drain("drain_checks");

    send_cmd(4'h9, 32'h0000_3000, 7, 2, 1);
    found  = 1'b0;
    budget = 0;
    while (!found && budget < 100) begin
      @(posedge aclk); #1;
      found = bus.beat_valid && bus.beat_idx == 8'd4;
      budget++;
    end
    check("reach_idx4", found, $sformatf("beat_idx=%0d valid=%0b, want idx 4 valid", bus.beat_idx, bus.beat_valid));
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_burst");
    repeat (3) @(posedge aclk);
    release_reset();
    send_cmd(4'hA, 32'h0000_4444, 0, 2, 1);
    drain("drain_after_reset");

    ready_all = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b  = int'($urandom_range(0, 3));
      sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      a  = $urandom;
      ln = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF0;
      if (b == 2) begin
        ln = wl[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      end
      send_cmd(IW'($urandom), a, ln, sz, b);
    end
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
